// File: rtl/keypad_scanner.sv
// Keypad matrix scanner: drives one row low at a time on each div_clk rising
// edge, classifies each four-row frame, and debounces presses/releases over
// DEBOUNCE consecutive identical frames.
module keypad_scanner #(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       div_clk,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [3:0] LP_DEB = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAND    = 2'd1,
        S_PRESSED = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // Frame counter increment that sticks at DEBOUNCE instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        sat_inc = (cnt >= LP_DEB) ? LP_DEB : cnt + 4'd1;
    endfunction

    logic [3:0] r_col_s1, r_col_s2;
    logic       r_div, r_div_d;
    logic [1:0] r_row;
    logic [1:0] r_acc_n;
    logic [3:0] r_acc_code;
    state_t     r_state;
    logic [3:0] r_cnt, r_cand, r_key_code;
    logic       r_key_valid;

    logic       w_tick;
    logic [3:0] w_low;
    logic [2:0] w_row_n, w_tot;
    logic [1:0] w_base_n, w_frame_n, w_col_idx;
    logic [3:0] w_frame_code;
    logic       w_frame_end, w_single;
    logic [3:0] w_cnt_inc;
    state_t     w_state_nxt;
    logic [3:0] w_cnt_nxt, w_cand_nxt, w_code_nxt;
    logic       w_valid_nxt;

    assign w_tick      = r_div & ~r_div_d;
    assign w_low       = ~r_col_s2;
    assign w_row_n     = {2'b00, w_low[0]} + {2'b00, w_low[1]} + {2'b00, w_low[2]} + {2'b00, w_low[3]};
    // Row 0 starts a fresh frame, so the accumulator from the previous frame is ignored.
    assign w_base_n    = (r_row == 2'd0) ? 2'd0 : r_acc_n;
    assign w_tot       = {1'b0, w_base_n} + w_row_n;
    // Count of closed contacts saturates at 2, which stands for "multiple".
    assign w_frame_n   = (w_tot >= 3'd2) ? 2'd2 : w_tot[1:0];
    assign w_frame_code = (w_row_n == 3'd1) ? {r_row, w_col_idx} : r_acc_code;
    assign w_frame_end = w_tick && (r_row == 2'd3);
    assign w_single    = (w_frame_n == 2'd1);
    assign w_cnt_inc   = sat_inc(r_cnt);

    assign row_out   = ~(4'b0001 << r_row);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = (r_state == S_PRESSED) || (r_state == S_RELEASE);

    // Column index of the closed contact when exactly one is low in this row.
    always_comb begin
        w_col_idx = 2'd0;
        if (w_low[1]) w_col_idx = 2'd1;
        if (w_low[2]) w_col_idx = 2'd2;
        if (w_low[3]) w_col_idx = 2'd3;
        if (w_low[0]) w_col_idx = 2'd0;
    end

    // Column synchronizer and div_clk edge history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col_s1 <= 4'b1111;
            r_col_s2 <= 4'b1111;
            r_div    <= 1'b0;
            r_div_d  <= 1'b0;
        end else begin
            r_col_s1 <= col_in;
            r_col_s2 <= r_col_s1;
            r_div    <= div_clk;
            r_div_d  <= r_div;
        end
    end

    // Row scan and per-frame accumulation of closed contacts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row      <= 2'd0;
            r_acc_n    <= 2'd0;
            r_acc_code <= 4'd0;
        end else if (w_tick) begin
            r_row      <= r_row + 2'd1;
            r_acc_n    <= w_frame_n;
            r_acc_code <= w_frame_code;
        end
    end

    // Debounce FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_cand      <= 4'd0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cand      <= w_cand_nxt;
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
        end
    end

    // Debounce FSM next state, evaluated only at frame end.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_code_nxt  = r_key_code;
        w_valid_nxt = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        w_cand_nxt = w_frame_code;
                        w_cnt_nxt  = 4'd1;
                        if (LP_DEB <= 4'd1) begin
                            w_state_nxt = S_PRESSED;
                            w_code_nxt  = w_frame_code;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_CAND;
                        end
                    end
                end
                S_CAND: begin
                    if (w_single && (w_frame_code == r_cand)) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == LP_DEB) begin
                            w_state_nxt = S_PRESSED;
                            w_code_nxt  = r_cand;
                            w_valid_nxt = 1'b1;
                        end
                    end else if (w_single) begin
                        w_cand_nxt = w_frame_code;
                        w_cnt_nxt  = 4'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                S_PRESSED: begin
                    if (!(w_single && (w_frame_code == r_key_code))) begin
                        if (LP_DEB <= 4'd1) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = 4'd0;
                        end else begin
                            w_state_nxt = S_RELEASE;
                            w_cnt_nxt   = 4'd1;
                        end
                    end
                end
                S_RELEASE: begin
                    if (w_single && (w_frame_code == r_key_code)) begin
                        w_state_nxt = S_PRESSED;
                    end else if (w_cnt_inc == LP_DEB) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

endmodule
